// File: rtl/vec_mem_pkg.sv
// Shared types and defaults for the SDRAM byte-port arbiter.
package vec_mem_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DL   = 2'd1,
    GNT_FDD  = 2'd2,
    GNT_CPU  = 2'd3
  } grant_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} arb_state_t;

  localparam int TIMEOUT_DEF   = 64;
  localparam int AGE_LIMIT_DEF = 4;

  // Bit positions in the request vector handed to the picker.
  localparam int REQ_DL  = 0;
  localparam int REQ_FDD = 1;
  localparam int REQ_CPU = 2;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational priority picker: dl > fdd > cpu, dl only while dl_active,
// cpu first when the age override is raised.
module ram_arb_pick
  import vec_mem_pkg::*;
(
  input  logic [2:0] req,
  input  logic       dl_active,
  input  logic       age_override,
  output grant_t     pick
);

  always_comb begin
    pick = GNT_NONE;
    if (dl_active) begin
      if (req[REQ_DL]) pick = GNT_DL;
    end else if (age_override && req[REQ_CPU]) pick = GNT_CPU;
    else if (req[REQ_DL])  pick = GNT_DL;
    else if (req[REQ_FDD]) pick = GNT_FDD;
    else if (req[REQ_CPU]) pick = GNT_CPU;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port SDRAM byte arbiter for loader / FDD / CPU, one access in flight.
// Optional CPU anti-starvation aging: define RAM_ARBITER_CPU_AGING_EN.
module ram_arbiter
  import vec_mem_pkg::*;
#(
  parameter int AW        = 25,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int AGE_LIMIT = AGE_LIMIT_DEF
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          dl_req,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_data,
  output logic          dl_ack,
  input  logic          dl_active,
  input  logic          fdd_req,
  input  logic [20:0]   fdd_addr,
  output logic          fdd_ack,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [19:0]   cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic          cpu_ack,
  output logic [7:0]    rd_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  input  logic [7:0]    mem_dout,
  input  logic          mem_ack,
  output grant_t        grant,
  output logic          timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  if (AGE_LIMIT < 1 || AGE_LIMIT > 7) begin : g_bad_age
    $error("AGE_LIMIT must fit the 3-bit age counter");
  end

  arb_state_t    state, state_nxt;
  logic [CW-1:0] wait_cnt;
  grant_t        pick;
  logic          age_override;
  logic          expired;

  ram_arb_pick u_pick (
    .req          ({cpu_req, fdd_req, dl_req}),
    .dl_active    (dl_active),
    .age_override (age_override),
    .pick         (pick)
  );

`ifdef RAM_ARBITER_CPU_AGING_EN
  logic [2:0] age;

  always_ff @(posedge clk_sys) begin
    if (reset || !cpu_req) age <= '0;
    else if (state == IDLE && pick != GNT_NONE) begin
      if (pick == GNT_CPU)  age <= '0;
      else if (age != 3'd7) age <= age + 3'd1;
    end
  end

  assign age_override = (int'(age) >= AGE_LIMIT);
`else
  assign age_override = 1'b0;
`endif

  // Counter starts at 0 on the first WAIT cycle; expiry lands TIMEOUT+2 after mem_req.
  assign expired = (wait_cnt == CW'(TIMEOUT));

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick != GNT_NONE) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (mem_ack || expired) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      grant       <= GNT_NONE;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_din     <= '0;
      rd_data     <= 8'hFF;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (pick != GNT_NONE) begin
          grant <= pick;
          case (pick)
            GNT_DL: begin
              mem_addr <= dl_addr;
              mem_we   <= 1'b1;
              mem_din  <= dl_data;
            end
            GNT_FDD: begin
              mem_addr <= AW'(fdd_addr);
              mem_we   <= 1'b0;
              mem_din  <= '0;
            end
            default: begin
              mem_addr <= AW'(cpu_addr);
              mem_we   <= cpu_we;
              mem_din  <= cpu_din;
            end
          endcase
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + CW'(1);
          if (mem_ack) begin
            if (!mem_we) rd_data <= mem_dout;
          end else if (expired) begin
            timeout_err <= 1'b1;
            if (!mem_we) rd_data <= 8'hFF;
          end
        end
        ACK:     grant <= GNT_NONE;
        default: ;
      endcase
    end
  end

  assign mem_req = (state == ISSUE);
  assign dl_ack  = (state == ACK) && (grant == GNT_DL);
  assign fdd_ack = (state == ACK) && (grant == GNT_FDD);
  assign cpu_ack = (state == ACK) && (grant == GNT_CPU);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed + randomized bench for ram_arbiter against a memory-map reference model.
module tb_ram_arbiter;
  import vec_mem_pkg::*;

  localparam int AW = 25, TIMEOUT = 64, AGE_LIMIT = 4;

  logic          clk_sys = 1'b0, reset = 1'b1;
  logic          dl_req = 0, dl_active = 0, fdd_req = 0, cpu_req = 0, cpu_we = 0;
  logic [AW-1:0] dl_addr = '0;
  logic [7:0]    dl_data = '0, cpu_din = '0;
  logic [20:0]   fdd_addr = '0;
  logic [19:0]   cpu_addr = '0;
  logic          dl_ack, fdd_ack, cpu_ack, mem_req, mem_we, mem_ack, timeout_err;
  logic [7:0]    rd_data, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;
  logic [1:0]    grant;

  ram_arbiter #(.AW(AW), .TIMEOUT(TIMEOUT), .AGE_LIMIT(AGE_LIMIT)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .dl_req(dl_req), .dl_addr(dl_addr), .dl_data(dl_data), .dl_ack(dl_ack), .dl_active(dl_active),
    .fdd_req(fdd_req), .fdd_addr(fdd_addr), .fdd_ack(fdd_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_ack(cpu_ack),
    .rd_data(rd_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ack(mem_ack), .grant(grant), .timeout_err(timeout_err)
  );

  always #21 clk_sys = ~clk_sys;

  int         checks = 0, errors = 0;
  logic [7:0] sram  [int];   // environment memory behind the port
  logic [7:0] model [int];   // reference: what the requesters have written
  logic [7:0] rd_model = 8'hFF;
  bit         resp_on = 1'b1;
  int         ack_dly = 1, pend_cnt = 0;
  logic [7:0] pend_dout = '0;

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mdl_rd(input logic [AW-1:0] a);
    return model.exists(int'(a)) ? model[int'(a)] : 8'h00;
  endfunction

  function automatic logic ack_of(input int who);
    case (who)
      1:       return dl_ack;
      2:       return fdd_ack;
      default: return cpu_ack;
    endcase
  endfunction

  task automatic set_req(input int who, input logic v);
    case (who)
      1:       dl_req = v;
      2:       fdd_req = v;
      default: cpu_req = v;
    endcase
  endtask

  // SRAM responder: acks ack_dly cycles after it sees mem_req.
  initial begin
    mem_ack = 1'b0; mem_dout = 8'h00;
    forever begin
      tick();
      if (resp_on) begin
        mem_ack = 1'b0;
        if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0) begin mem_ack = 1'b1; mem_dout = pend_dout; end
        end
        if (mem_req) begin
          if (mem_we) sram[int'(mem_addr)] = mem_din;
          pend_dout = sram.exists(int'(mem_addr)) ? sram[int'(mem_addr)] : 8'h00;
          pend_cnt  = ack_dly;
        end
      end
    end
  end

  // One isolated access; who: 1=dl, 2=fdd, 3=cpu.
  task automatic xact(input int who, input logic we, input logic [AW-1:0] addr,
                      input logic [7:0] d, input int dly);
    int n;
    logic [7:0] exp_rd;
    exp_rd  = we ? rd_model : mdl_rd(addr);
    ack_dly = dly;
    case (who)
      1:       begin dl_req = 1; dl_addr = addr; dl_data = d; end
      2:       begin fdd_req = 1; fdd_addr = addr[20:0]; end
      default: begin cpu_req = 1; cpu_we = we; cpu_addr = addr[19:0]; cpu_din = d; end
    endcase
    tick();
    chk("issue_mem_req", mem_req, 1);
    chk("issue_grant", grant, who);
    chk("issue_addr", mem_addr, addr);
    chk("issue_we", mem_we, we);
    if (we) chk("issue_din", mem_din, d);
    n = 0;
    while (!ack_of(who) && n < TIMEOUT + 8) begin tick(); n++; end
    chk("ack_latency", n, dly + 1);
    chk("rd_data", rd_data, exp_rd);
    set_req(who, 0);
    if (we) model[int'(addr)] = d; else rd_model = exp_rd;
    tick();
    chk("ack_one_cycle", ack_of(who), 0);
    chk("idle_grant", grant, GNT_NONE);
  endtask

  initial begin
    int n, fcnt, fbefore, overlap, exp_before;
    int order[$];
    logic [7:0] fdd_got, cpu_got, d;
    logic [AW-1:0] pool[4];
    pool[0] = 25'h0000010; pool[1] = 25'h0080003; pool[2] = 25'h00FFFFF; pool[3] = 25'h0001234;

    // Reset state
    tick(); tick();
    reset = 0;
    tick();
    chk("rst_grant", grant, GNT_NONE);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_rd_data", rd_data, 8'hFF);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_acks", {dl_ack, fdd_ack, cpu_ack}, 0);

    // CPU read 0_1234 returning 5A, mem_ack 3 cycles after mem_req
    sram[32'h1234] = 8'h5A; model[32'h1234] = 8'h5A;
    xact(3, 0, 25'h0001234, 8'h00, 3);

    // Reset mid-WAIT; a late mem_ack must be ignored
    resp_on = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00010;
    tick(); tick(); tick();
    reset = 1; cpu_req = 0;
    tick();
    chk("rstw_grant", grant, GNT_NONE);
    chk("rstw_mem_req", mem_req, 0);
    chk("rstw_rd_data", rd_data, 8'hFF);
    reset = 0; rd_model = 8'hFF;
    tick(); tick();
    mem_ack = 1; mem_dout = 8'h33;
    tick();
    mem_ack = 0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (cpu_ack || grant != GNT_NONE) n++;
      tick();
    end
    chk("rstw_no_late_ack", n, 0);
    resp_on = 1;

    // Width: high loader address and FDD address with bit 20 set
    xact(1, 1, 25'h1ABCDEF, 8'h3C, 1);
    sram[32'h1F0001] = 8'h77; model[32'h1F0001] = 8'h77;
    xact(2, 0, 25'h01F0001, 8'h00, 2);

    // Randomized isolated accesses
    for (int i = 0; i < 12; i++) begin
      int who;
      logic we;
      who = $urandom_range(1, 3);
      we  = (who == 1) ? 1'b1 : (who == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      d   = 8'($urandom_range(0, 254));
      xact(who, we, pool[$urandom_range(0, 3)], d, $urandom_range(1, 4));
    end

    // All three at once: dl writes A, fdd reads A, cpu reads B
    d = 8'($urandom_range(0, 254));
    ack_dly = 2;
    dl_req = 1; dl_addr = pool[0]; dl_data = d;
    fdd_req = 1; fdd_addr = pool[0][20:0];
    cpu_req = 1; cpu_we = 0; cpu_addr = pool[1][19:0];
    overlap = 0; n = 0; fdd_got = 0; cpu_got = 0;
    while ((dl_req || fdd_req || cpu_req) && n < 100) begin
      tick(); n++;
      if (int'(dl_ack) + int'(fdd_ack) + int'(cpu_ack) > 1) overlap++;
      if (dl_ack)  begin order.push_back(1); dl_req = 0; end
      if (fdd_ack) begin order.push_back(2); fdd_req = 0; fdd_got = rd_data; end
      if (cpu_ack) begin order.push_back(3); cpu_req = 0; cpu_got = rd_data; end
    end
    model[int'(pool[0])] = d;
    chk("sim_count", order.size(), 3);
    chk("sim_overlap", overlap, 0);
    if (order.size() == 3) begin
      chk("sim_first_dl", order[0], 1);
      chk("sim_second_fdd", order[1], 2);
      chk("sim_third_cpu", order[2], 3);
    end
    chk("sim_fdd_data", fdd_got, d);
    chk("sim_cpu_data", cpu_got, mdl_rd(pool[1]));
    rd_model = cpu_got;
    tick();

    // dl_active blocks fdd
    dl_active = 1; fdd_req = 1; fdd_addr = pool[2][20:0]; ack_dly = 1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (grant != GNT_NONE || mem_req) n++;
    end
    chk("dlact_blocked", n, 0);
    dl_active = 0;
    n = 0;
    while (grant != GNT_FDD && n < 6) begin tick(); n++; end
    chk("dlact_release_le2", (n >= 1 && n <= 2), 1);
    n = 0;
    while (!fdd_ack && n < 20) begin tick(); n++; end
    chk("dlact_fdd_ack", fdd_ack, 1);
    chk("dlact_fdd_data", rd_data, mdl_rd(pool[2]));
    rd_model = mdl_rd(pool[2]);
    fdd_req = 0;
    tick(); tick();

    // Continuous fdd vs pending cpu read
    ack_dly = 1;
    fdd_req = 1; fdd_addr = pool[3][20:0];
    cpu_req = 1; cpu_we = 0; cpu_addr = pool[1][19:0];
    fcnt = 0; fbefore = -1; overlap = 0; n = 0;
    while ((fdd_req || cpu_req) && n < 400) begin
      tick(); n++;
      if (fdd_ack && cpu_ack) overlap++;
      if (fdd_ack) begin fcnt++; if (fcnt == 6) fdd_req = 0; end
      if (cpu_ack) begin fbefore = fcnt; cpu_req = 0; end
    end
`ifdef RAM_ARBITER_CPU_AGING_EN
    exp_before = AGE_LIMIT;
`else
    exp_before = 6;
`endif
    chk("age_fdd_before_cpu", fbefore, exp_before);
    chk("age_overlap", overlap, 0);
    fdd_req = 0; cpu_req = 0;
    tick(); tick();
    // make sure the timeout read below overwrites a non-FF value
    sram[int'(pool[0])] = 8'h21; model[int'(pool[0])] = 8'h21;
    xact(3, 0, pool[0], 8'h00, 1);

    // Timeout: mem_ack withheld
    resp_on = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = pool[2][19:0];
    tick();
    chk("to_mem_req", mem_req, 1);
    n = 0;
    while (!cpu_ack && n < TIMEOUT + 10) begin tick(); n++; end
    chk("to_ack_latency", n, TIMEOUT + 2);
    chk("to_rd_data", rd_data, 8'hFF);
    chk("to_err", timeout_err, 1);
    cpu_req = 0; rd_model = 8'hFF;
    resp_on = 1;
    tick();
    xact(1, 1, pool[3], 8'h4D, 2);
    chk("to_err_sticky", timeout_err, 1);
    reset = 1;
    tick();
    reset = 0;
    tick();
    chk("to_err_cleared", timeout_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
